// File: rtl/deserializador_fifo.sv
// deserializador_fifo
// Serial-to-parallel converter feeding a small word FIFO.
//
// Incoming bits are accepted on rising edges where write_in=1 and the buffer
// is not full. After WIDTH accepted bits, the assembled word is written into
// a DEPTH-entry FIFO. A consumer reads the oldest word on data_out while
// data_ready=1, and pops it by raising ack_in.
//
// Optional feature: define DESER_PARITY_EN to expect one extra even-parity
// bit after each word. Words with bad parity are dropped, and parity_err
// pulses high for one cycle.
//
// Parameters
//   WIDTH     : word width in bits (>= 2)
//   DEPTH     : FIFO depth in words (power of two, >= 2)
//   MSB_FIRST : 1 = first received bit ends up in bit WIDTH-1,
//               0 = first received bit ends up in bit 0
//
// Ports
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high
//   data_in    : serial data bit
//   write_in   : data_in is valid this cycle
//   ack_in     : consumer takes data_out this cycle
//   status_out : buffer full, serial bits are refused
//   data_out   : oldest buffered word, zero while the buffer is empty
//   data_ready : buffer non-empty
//   parity_err : one-cycle pulse when a word is rejected for bad parity
module deserializador_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_in,
    input  logic             write_in,
    input  logic             ack_in,
    output logic             status_out,
    output logic [WIDTH-1:0] data_out,
    output logic             data_ready,
    output logic             parity_err
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [OW-1:0] FULL_COUNT = OW'(DEPTH);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, RECV, PARITY} state_t;
`else
    typedef enum logic {IDLE, RECV} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_cnt_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] push_word;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [OW-1:0]    count;
    logic             accept;
    logic             shift_en;
    logic             push;
    logic             pop;
`ifdef DESER_PARITY_EN
    logic             parity_bad;
`endif

    // Full and ready flags come straight from the occupancy register.
    assign status_out = (count == FULL_COUNT);
    assign data_ready = (count != '0);
    assign accept     = write_in && !status_out;
    assign pop        = ack_in && data_ready;
    assign data_out   = data_ready ? mem[rd_ptr] : '0;

    // Shifting in the chosen direction places the first bit at the requested
    // end after exactly WIDTH shifts, so stale bits from a previous word are
    // always pushed out before the word is used.
    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST != 0) begin
            shift_next = {shift_reg[WIDTH-2:0], data_in};
        end else begin
            shift_next = {data_in, shift_reg[WIDTH-1:1]};
        end
    end

    // Without parity the word is pushed on the edge that accepts its last bit,
    // so that bit must be taken from shift_next. With parity the word is
    // already complete in shift_reg when the parity bit arrives.
`ifdef DESER_PARITY_EN
    assign push_word = shift_reg;
`else
    assign push_word = shift_next;
`endif

    // Next-state logic for the receiver. The bit count only advances on
    // accepted bits, so a partial word waits indefinitely at its position.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_en     = 1'b0;
        push         = 1'b0;
`ifdef DESER_PARITY_EN
        parity_bad   = 1'b0;
`endif
        case (state)
            IDLE, RECV: begin
                if (accept) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
`ifdef DESER_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = IDLE;
                        push         = 1'b1;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + CW'(1);
                        state_next   = RECV;
                    end
                end
            end
`ifdef DESER_PARITY_EN
            PARITY: begin
                if (accept) begin
                    state_next = IDLE;
                    // Even parity: data plus parity bit must XOR to zero.
                    if (^{shift_reg, data_in}) begin
                        parity_bad = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    // Shift register, FIFO pointers and occupancy. Pointers wrap naturally
    // because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_reg <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            if (shift_en) begin
                shift_reg <= shift_next;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; empty entries are never visible
    // because data_out is forced to zero while the buffer is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

`ifdef DESER_PARITY_EN
    // Registered so the error shows as a single-cycle pulse after the
    // rejected parity bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/deserializador_fifo.md
DESERIALIZADOR_FIFO -- requirements
Module: deserializador_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, deserialised word width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-003 SHALL have parameter MSB_FIRST, default 1, bit order: 1 = first received bit lands in bit WIDTH-1, 0 = first bit lands in bit 0.
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port data_in  input  1  serial data bit.
REQ-007 SHALL have port write_in  input  1  data_in valid this cycle.
REQ-008 SHALL have port ack_in  input  1  consumer accepts data_out this cycle.
REQ-009 SHALL have port status_out  output  1  1 = buffer full, serial bits refused.
REQ-010 SHALL have port data_out  output  WIDTH  oldest buffered word.
REQ-011 SHALL have port data_ready  output  1  buffer non-empty, data_out valid.
REQ-012 SHALL have port parity_err  output  1  one-cycle pulse on rejected word (see Configuration).

Function
REQ-013 SHALL accept a bit only on an edge where write_in=1 and status_out=0; write_in while status_out=1 is ignored and the bit discarded.
REQ-014 SHALL use FSM IDLE (bit count 0) -> RECV on first accepted bit; RECV -> IDLE after the WIDTH-th accepted data bit (-> PARITY instead when DESER_PARITY_EN defined).
REQ-015 SHALL place accepted bits per MSB_FIRST, bit count running 0..WIDTH-1 then wrapping to 0.
REQ-016 SHALL write the completed word (including the final bit) into the buffer on the edge that accepts the final bit; data_ready=1 and data_out valid the following cycle (latency 1 cycle from final bit).
REQ-017 SHALL present the buffer head on data_out while data_ready=1, and drive data_out to all zeros while the buffer is empty.
REQ-018 SHALL pop the head on an edge with ack_in=1 and data_ready=1; ack_in with data_ready=0 has no effect.
REQ-019 SHALL, on simultaneous push and pop, keep occupancy unchanged, advance data_out to the next word, and append the new word.
REQ-020 SHALL drive status_out=1 exactly when occupancy equals DEPTH (registered, same cycle as occupancy change).
REQ-021 SHALL retain a partial word across any number of cycles with write_in=0 or status_out=1, resuming at the same bit position.
REQ-022 SHALL wrap read/write pointers modulo DEPTH with no loss or duplication of words.

Reset
REQ-023 SHALL, on reset=1 at an edge, empty the buffer, clear shift register and bit count, enter IDLE, and drive status_out=0, data_ready=0, data_out=0, parity_err=0 from the next cycle.
REQ-024 SHALL discard any partial word and all buffered words on reset mid-operation; reset has priority over write_in and ack_in.

Configuration
REQ-025 SHALL, with macro DESER_PARITY_EN defined, consume one extra accepted bit after the WIDTH data bits as even parity (data bits + parity bit have an even count of ones), in state PARITY.
REQ-026 SHALL, with DESER_PARITY_EN defined, push the word on the parity-bit edge only if parity is correct; on mismatch drop the word, pulse parity_err=1 for one cycle, and return to IDLE.
REQ-027 SHALL, without DESER_PARITY_EN, omit state PARITY, push on the WIDTH-th bit, and tie parity_err to 0.

Verification
REQ-028 SHALL cover: WIDTH=8, MSB_FIRST=1, serial 1,0,1,0,0,1,0,1 -> data_ready=1 one cycle after last bit, data_out=8'hA5; ack_in -> data_ready=0, data_out=8'h00.
REQ-029 SHALL cover: MSB_FIRST=0, same serial stream -> data_out=8'hA5 bit-reversed = 8'hA5 (palindrome) then stream 1,0,0,0,0,0,0,0 -> data_out=8'h01.
REQ-030 SHALL cover: DEPTH=4, push words 01,02,03,04 without ack -> status_out=1; further write_in bits ignored; one ack -> status_out=0, data_out=8'h02.
REQ-031 SHALL cover: final bit of 8'h55 accepted same edge as ack of 8'h11 with one word buffered -> occupancy stays 1, data_out=8'h55.
REQ-032 SHALL cover: reset asserted after 5 bits with 2 words buffered -> next cycle data_ready=0, status_out=0; fresh 8 bits of 8'h3C -> data_out=8'h3C.
REQ-033 SHALL cover (DESER_PARITY_EN): 8'hA5 + parity 0 -> pushed; 8'hA5 + parity 1 -> not pushed, parity_err=1 for exactly one cycle.
